// File: rtl/smem_pkg.sv
// Shared types and constants for the SMEM result packer: record/tag layout,
// FSM state encoding and the batch terminator line.
package smem_pkg;

  localparam int unsigned CL             = 512;
  localparam int unsigned READ_NUM_WIDTH = 6;
  localparam int unsigned RECORD_W       = 256;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StFlush,
    StTerm,
    StDone
  } state_e;

  typedef struct packed {
    logic                      last;
    logic                      valid;
    logic [READ_NUM_WIDTH-1:0] read_num;
  } tag_t;

  typedef struct packed {
    tag_t        tag;
    logic [55:0] info;
    logic [63:0] x2;
    logic [63:0] x1;
    logic [63:0] x0;
  } record_t;

  localparam logic [CL-1:0] TERMINATOR = '1;

endpackage

// File: rtl/smem_result_packer_if.sv
// Result-beat input stream plus packed-line output stream of the packer.
interface smem_result_packer_if #(
  parameter int unsigned CL             = smem_pkg::CL,
  parameter int unsigned READ_NUM_WIDTH = smem_pkg::READ_NUM_WIDTH
);

  logic                      result_valid;
  logic [READ_NUM_WIDTH-1:0] result_read_num;
  logic                      result_last;
  logic [63:0]               result_ik_x0;
  logic [63:0]               result_ik_x1;
  logic [63:0]               result_ik_x2;
  logic [63:0]               result_ik_info;
  logic                      stall;
  logic                      out_valid;
  logic [CL-1:0]             out_data;
  logic                      out_ready;

  modport master (
    output result_valid, result_read_num, result_last,
    output result_ik_x0, result_ik_x1, result_ik_x2, result_ik_info,
    output out_ready,
    input  stall, out_valid, out_data
  );

  modport slave (
    input  result_valid, result_read_num, result_last,
    input  result_ik_x0, result_ik_x1, result_ik_x2, result_ik_info,
    input  out_ready,
    output stall, out_valid, out_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; dout reads zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/smem_result_packer.sv
// Packs SMEM result beats two records per output line, flushes a trailing
// half line and appends an all-ones terminator once every read has finished.
module smem_result_packer #(
  parameter int unsigned CL             = smem_pkg::CL,
  parameter int unsigned READ_NUM_WIDTH = smem_pkg::READ_NUM_WIDTH,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [READ_NUM_WIDTH:0] batch_size,
  input  logic                    start,
  output logic                    batch_done,
  output logic                    error,
  smem_result_packer_if.slave     bus
);

  import smem_pkg::*;

  localparam int unsigned BW = READ_NUM_WIDTH + 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  state_e        state_q, state_d;
  logic [BW-1:0] batch_q, batch_d;
  logic [BW-1:0] finished_q, finished_d;
  record_t       half_q, half_d;
  logic          half_valid_q, half_valid_d;
  logic          error_q, error_d;

  record_t       beat_rec;
  logic [CL-1:0] pair_line, flush_line, push_data, fifo_dout;
  logic          push, pop, accept;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          unused_info;

  // Upper info byte is overwritten by the tag in the record layout.
  assign unused_info = ^bus.result_ik_info[63:56];

  assign bus.stall     = (fifo_count >= CW'(FIFO_DEPTH - 1)) || (state_q != StCollect);
  assign accept        = bus.result_valid && !bus.stall;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_dout;
  assign pop           = bus.out_valid && bus.out_ready;
  assign batch_done    = (state_q == StDone);
  assign error         = error_q;

  always_comb begin
    beat_rec.tag.last     = bus.result_last;
    beat_rec.tag.valid    = 1'b1;
    beat_rec.tag.read_num = bus.result_read_num;
    beat_rec.info         = bus.result_ik_info[55:0];
    beat_rec.x2           = bus.result_ik_x2;
    beat_rec.x1           = bus.result_ik_x1;
    beat_rec.x0           = bus.result_ik_x0;
  end

  always_comb begin
    pair_line                      = '0;
    pair_line[2*RECORD_W-1:0]      = {beat_rec, half_q};
    flush_line                     = '0;
    flush_line[RECORD_W-1:0]       = half_q;
  end

  always_comb begin
    state_d      = state_q;
    batch_d      = batch_q;
    finished_d   = finished_q;
    half_d       = half_q;
    half_valid_d = half_valid_q;
    error_d      = error_q;
    push         = 1'b0;
    push_data    = '0;

    // Beats offered while stalled are lost, so flag them.
    if (bus.result_valid && bus.stall) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          batch_d      = batch_size;
          finished_d   = '0;
          half_valid_d = 1'b0;
          state_d      = (batch_size == '0) ? StTerm : StCollect;
        end
      end
      StCollect: begin
        if (start) error_d = 1'b1;
        if (accept) begin
          if (half_valid_q) begin
            push         = 1'b1;
            push_data    = pair_line;
            half_valid_d = 1'b0;
          end else begin
            half_d       = beat_rec;
            half_valid_d = 1'b1;
          end
          if (bus.result_last) begin
            finished_d = finished_q + BW'(1);
            if (finished_d == batch_q) state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (start) error_d = 1'b1;
        if (!half_valid_q) begin
          state_d = StTerm;
        end else if (!fifo_full) begin
          push         = 1'b1;
          push_data    = flush_line;
          half_valid_d = 1'b0;
          state_d      = StTerm;
        end
      end
      StTerm: begin
        if (start) error_d = 1'b1;
        if (!fifo_full) begin
          push      = 1'b1;
          push_data = TERMINATOR;
          state_d   = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      batch_q      <= '0;
      finished_q   <= '0;
      half_q       <= '0;
      half_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      batch_q      <= batch_d;
      finished_q   <= finished_d;
      half_q       <= half_d;
      half_valid_q <= half_valid_d;
      error_q      <= error_d;
    end
  end

  sync_fifo #(
    .WIDTH (CL),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_smem_result_packer.sv
// Randomized scenario bench for smem_result_packer against a queue-based
// model of record pairing, half-line flush and terminator emission.
module tb_smem_result_packer;

  localparam int unsigned CL       = 512;
  localparam int unsigned RNW      = 6;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned BW       = RNW + 1;
  localparam int          MAX_WAIT = 2000;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] batch_size;
  logic          start;
  logic          batch_done;
  logic          error;
  bit            rand_ready;

  int checks = 0;
  int errors = 0;

  logic [CL-1:0]  got[$];
  logic [CL-1:0]  exp_q[$];
  logic [255:0]   recs[$];

  smem_result_packer_if #(.CL(CL), .READ_NUM_WIDTH(RNW)) bus ();

  smem_result_packer #(
    .CL             (CL),
    .READ_NUM_WIDTH (RNW),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .batch_size (batch_size),
    .start      (start),
    .batch_done (batch_done),
    .error      (error),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Capture every line that the next rising edge will pop.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
  end

  function automatic logic [255:0] make_rec(input bit last, input int rn,
                                            input logic [63:0] x0, input logic [63:0] x1,
                                            input logic [63:0] x2, input logic [63:0] info);
    logic [7:0] tag;
    tag = {last, 1'b1, RNW'(rn)};
    return {tag, info[55:0], x2, x1, x0};
  endfunction

  // Accepted records -> expected lines: pairs, zero-padded odd tail, terminator.
  function automatic void model_batch();
    logic [CL-1:0] l;
    for (int i = 0; i < recs.size(); i += 2) begin
      l = '0;
      if (i + 1 < recs.size()) l[511:0] = {recs[i+1], recs[i]};
      else l[255:0] = recs[i];
      exp_q.push_back(l);
    end
    l = '1;
    exp_q.push_back(l);
    recs.delete();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_start(input int n);
    batch_size = BW'(n);
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic drive_payload(output logic [255:0] rec, input int rn, input bit last);
    logic [63:0] x0, x1, x2, info;
    x0   = {$urandom, $urandom};
    x1   = {$urandom, $urandom};
    x2   = {$urandom, $urandom};
    info = {$urandom, $urandom};
    bus.result_read_num = RNW'(rn);
    bus.result_last     = last;
    bus.result_ik_x0    = x0;
    bus.result_ik_x1    = x1;
    bus.result_ik_x2    = x2;
    bus.result_ik_info  = info;
    rec = make_rec(last, rn, x0, x1, x2, info);
  endtask

  task automatic send_beat(input int rn, input bit last);
    logic [255:0] rec;
    int waited = 0;
    while (bus.stall && waited < MAX_WAIT) begin
      step();
      waited++;
    end
    checks++;
    if (bus.stall) begin
      errors++;
      $display("FAIL send_beat_wait: stall=%0b after %0d cycles, required 0", bus.stall, waited);
    end else begin
      drive_payload(rec, rn, last);
      bus.result_valid = 1'b1;
      step();
      bus.result_valid = 1'b0;
      recs.push_back(rec);
    end
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (!(batch_done && !bus.out_valid) && n < MAX_WAIT) begin
      step();
      n++;
    end
    ok = batch_done && !bus.out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++;
      $display("FAIL reset_out_data: got %h required 0", bus.out_data); end
    checks++; if (batch_done !== 1'b0) begin errors++;
      $display("FAIL reset_batch_done: got %b required 0", batch_done); end
    checks++; if (error !== 1'b0) begin errors++;
      $display("FAIL reset_error: got %b required 0", error); end
    checks++; if (bus.stall !== 1'b1) begin errors++;
      $display("FAIL reset_stall: got %b required 1", bus.stall); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_two_reads();
    bit ok;
    got.delete(); exp_q.delete(); recs.delete();
    bus.out_ready = 1'b1;
    do_start(2);
    send_beat(0, 1'b1);
    send_beat(1, 1'b1);
    model_batch();
    wait_done(ok);
    checks++; if (!ok) begin errors++;
      $display("FAIL two_reads_done: batch_done=%b out_valid=%b required 1/0",
               batch_done, bus.out_valid); end
    checks++; if (got.size() !== exp_q.size()) begin errors++;
      $display("FAIL two_reads_count: got %0d lines required %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++;
        $display("FAIL two_reads_line%0d: got %h required %h", i, got[i], exp_q[i]); end
    end
    if (got.size() > 0) begin
      checks++; if (got[0][255:248] !== 8'hC0 || got[0][511:504] !== 8'hC1) begin errors++;
        $display("FAIL two_reads_tags: got %h/%h required c0/c1", got[0][255:248],
                 got[0][511:504]); end
    end
    checks++; if (batch_done !== 1'b1) begin errors++;
      $display("FAIL two_reads_batch_done: got %b required 1", batch_done); end
  endtask

  task automatic test_odd_flush();
    bit ok;
    logic [CL-1:0] first;
    got.delete(); exp_q.delete(); recs.delete();
    bus.out_ready = 1'b0;
    do_start(1);
    send_beat(0, 1'b0);
    send_beat(0, 1'b0);
    first = '0;
    if (recs.size() == 2) first[511:0] = {recs[1], recs[0]};
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== first) begin errors++;
      $display("FAIL odd_latency: out_valid=%b data=%h required 1 data=%h",
               bus.out_valid, bus.out_data, first); end
    send_beat(0, 1'b1);
    model_batch();
    bus.out_ready = 1'b1;
    wait_done(ok);
    checks++; if (!ok) begin errors++;
      $display("FAIL odd_done: batch_done=%b out_valid=%b required 1/0",
               batch_done, bus.out_valid); end
    checks++; if (got.size() !== exp_q.size()) begin errors++;
      $display("FAIL odd_count: got %0d lines required %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++;
        $display("FAIL odd_line%0d: got %h required %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall_error();
    bit ok;
    logic [255:0] dropped;
    logic [CL-1:0] l;
    got.delete(); exp_q.delete(); recs.delete();
    bus.out_ready = 1'b0;
    do_start(1);
    repeat (4) send_beat(0, 1'b0);
    checks++; if (bus.stall !== 1'b0) begin errors++;
      $display("FAIL stall_count2: got %b required 0", bus.stall); end
    repeat (2) send_beat(0, 1'b0);
    checks++; if (bus.stall !== 1'b1) begin errors++;
      $display("FAIL stall_count3: got %b required 1", bus.stall); end
    drive_payload(dropped, 5, 1'b1);
    bus.result_valid = 1'b1;
    step();
    bus.result_valid = 1'b0;
    checks++; if (error !== 1'b1) begin errors++;
      $display("FAIL stall_error_flag: got %b required 1", error); end
    bus.out_ready = 1'b1;
    repeat (8) step();
    checks++; if (got.size() !== 3) begin errors++;
      $display("FAIL stall_lines: got %0d lines required 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3 && 2 * i + 1 < recs.size(); i++) begin
      l = '0;
      l[511:0] = {recs[2*i+1], recs[2*i]};
      checks++; if (got[i] !== l) begin errors++;
        $display("FAIL stall_line%0d: got %h required %h", i, got[i], l); end
    end
    got.delete(); recs.delete();
    send_beat(1, 1'b1);
    model_batch();
    wait_done(ok);
    checks++; if (!ok || got.size() !== exp_q.size()) begin errors++;
      $display("FAIL stall_finish: done=%b lines=%0d required 1 and %0d",
               ok, got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++;
        $display("FAIL stall_tail%0d: got %h required %h", i, got[i], exp_q[i]); end
    end
    checks++; if (error !== 1'b1) begin errors++;
      $display("FAIL stall_error_sticky: got %b required 1", error); end
  endtask

  task automatic test_reset_mid_batch();
    bit ok;
    got.delete(); exp_q.delete(); recs.delete();
    bus.out_ready = 1'b0;
    do_start(8);
    repeat (5) send_beat(0, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++;
      $display("FAIL midrst_queued: out_valid=%b required 1", bus.out_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || batch_done !== 1'b0 || bus.stall !== 1'b1
                  || error !== 1'b0) begin errors++;
      $display("FAIL midrst_state: valid=%b done=%b stall=%b error=%b required 0 0 1 0",
               bus.out_valid, batch_done, bus.stall, error); end
    got.delete(); recs.delete();
    bus.out_ready = 1'b1;
    repeat (5) step();
    checks++; if (got.size() !== 0) begin errors++;
      $display("FAIL midrst_stale: got %0d lines required 0", got.size()); end
    do_start(1);
    send_beat(3, 1'b1);
    model_batch();
    wait_done(ok);
    checks++; if (!ok || got.size() !== exp_q.size()) begin errors++;
      $display("FAIL midrst_restart: done=%b lines=%0d required 1 and %0d",
               ok, got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++;
        $display("FAIL midrst_line%0d: got %h required %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    logic [CL-1:0] term;
    got.delete(); exp_q.delete(); recs.delete();
    rand_ready = 1'b1;
    do_start(64);
    for (int r = 0; r < 64; r++) begin
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) send_beat(r, k == n - 1);
    end
    model_batch();
    wait_done(ok);
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (!ok) begin errors++;
      $display("FAIL random_done: batch_done=%b out_valid=%b required 1/0",
               batch_done, bus.out_valid); end
    checks++; if (got.size() !== exp_q.size()) begin errors++;
      $display("FAIL random_count: got %0d lines required %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++;
        $display("FAIL random_line%0d: got %h required %h", i, got[i], exp_q[i]); end
    end
    term = '1;
    if (got.size() > 0) begin
      checks++; if (got[got.size()-1] !== term) begin errors++;
        $display("FAIL random_terminator: got %h required all ones", got[got.size()-1]); end
    end
    checks++; if (error !== 1'b0) begin errors++;
      $display("FAIL random_error: got %b required 0", error); end
  endtask

  task automatic test_zero_batch();
    bit ok;
    logic [CL-1:0] term;
    got.delete(); exp_q.delete(); recs.delete();
    bus.out_ready = 1'b1;
    do_start(0);
    wait_done(ok);
    term = '1;
    checks++; if (!ok || batch_done !== 1'b1) begin errors++;
      $display("FAIL zero_done: done=%b batch_done=%b required 1", ok, batch_done); end
    checks++; if (got.size() !== 1) begin errors++;
      $display("FAIL zero_count: got %0d lines required 1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0] !== term) begin errors++;
        $display("FAIL zero_line: got %h required all ones", got[0]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset               = 1'b1;
    start               = 1'b0;
    batch_size          = '0;
    rand_ready          = 1'b0;
    bus.result_valid    = 1'b0;
    bus.result_read_num = '0;
    bus.result_last     = 1'b0;
    bus.result_ik_x0    = '0;
    bus.result_ik_x1    = '0;
    bus.result_ik_x2    = '0;
    bus.result_ik_info  = '0;
    bus.out_ready       = 1'b0;
    test_reset();
    test_two_reads();
    test_odd_flush();
    test_stall_error();
    test_reset_mid_batch();
    test_random();
    test_zero_batch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/smem_result_packer.md
SMEM_RESULT_PACKER -- requirements
Module: smem_result_packer

Interface
REQ-001 Parameters SHALL be: CL, default 512, output line width; READ_NUM_WIDTH, default 6, read index width; FIFO_DEPTH, default 4, output line buffer depth.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 batch_size  input  READ_NUM_WIDTH+1  number of reads in the batch; sampled on start.
REQ-005 start  input  1  one-cycle pulse that begins a batch.
REQ-006 result_valid  input  1  result beat present.
REQ-007 result_read_num  input  READ_NUM_WIDTH  read that produced the result.
REQ-008 result_last  input  1  final result of that read.
REQ-009 result_ik_x0, result_ik_x1, result_ik_x2, result_ik_info  input  64 each  SMEM interval.
REQ-010 stall  output  1  upstream hold request.
REQ-011 out_valid  output  1  output line available.
REQ-012 out_data  output  CL  packed output line.
REQ-013 out_ready  input  1  downstream accepts line.
REQ-014 batch_done  output  1  batch fully emitted.
REQ-015 error  output  1  sticky protocol-violation flag.

Function
REQ-016 Record (256 b) SHALL be {tag[7:0], info[55:0], x2, x1, x0}, x0 at LSB; tag = {result_last, 1'b1, result_read_num}.
REQ-017 Two records SHALL pack per line: first record in [255:0], second in [511:256].
REQ-018 FSM states SHALL be IDLE, COLLECT, FLUSH, TERM, DONE.
REQ-019 IDLE->COLLECT on start; batch_size latched, reads_finished and half flag cleared.
REQ-020 start with batch_size==0 SHALL go IDLE->TERM directly.
REQ-021 In COLLECT, accepted beat = result_valid && !stall; first beat is held in the half register, second beat completes the line and pushes it to the FIFO.
REQ-022 reads_finished SHALL increment on each accepted beat with result_last=1; when the increment reaches batch_size, next state SHALL be FLUSH.
REQ-023 FLUSH: if half pending, push {256'b0, half} when FIFO not full; then TERM; if no half pending, go to TERM in one cycle.
REQ-024 TERM SHALL push the terminator line (all ones) when FIFO not full, then go to DONE.
REQ-025 DONE SHALL hold batch_done=1 until start (to COLLECT, as REQ-019) or reset.
REQ-026 stall SHALL be combinational: 1 when FIFO count >= FIFO_DEPTH-1, or state is not COLLECT.
REQ-027 result_valid while stall=1 SHALL be dropped and SHALL set error; it is sticky until reset.
REQ-028 start outside IDLE/DONE SHALL be ignored and SHALL set error.
REQ-029 out_valid = FIFO non-empty; out_data = FIFO head; pop on out_valid && out_ready.
REQ-030 A push and a pop in the same cycle SHALL leave the count unchanged; a push is never issued when the FIFO is full.
REQ-031 Latency: a line completed at edge N SHALL be visible on out_valid/out_data after edge N+1 when the FIFO was empty.
REQ-032 Line order on out_data SHALL equal push order; no line is dropped or duplicated under any out_ready pattern.

Reset
REQ-033 On reset: state IDLE, FIFO empty, half flag 0, reads_finished 0, out_valid 0, out_data 0, batch_done 0, error 0, stall 1.
REQ-034 Reset mid-batch SHALL discard the half register and all FIFO contents with no further output.

Structure
REQ-035 CL, READ_NUM_WIDTH, the FSM state enum, the tag layout and the terminator constant SHALL live in shared package smem_pkg.
REQ-036 The FIFO SHALL be sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, count, full, empty).

Verification
REQ-037 batch_size=2, out_ready=1, beats A(read0, last) then B(read1, last) -> one line {B,A} with tags 8'hC0/8'hC1, then an all-ones line, then batch_done=1.
REQ-038 batch_size=1, three beats (read0, last only on the third) -> line {r1,r0}, then {0,r2}, then the terminator line.
REQ-039 out_ready=0 while beats keep arriving -> stall rises when count=3; a beat presented under stall sets error=1 and is not emitted.
REQ-040 Random out_ready, 64 reads with 1-4 results each -> every record emitted exactly once, in order; final line is the terminator.
REQ-041 reset pulsed with a half record pending and 2 lines queued -> next cycle out_valid=0, batch_done=0, stall=1; no stale line after a new start.
REQ-042 start with batch_size=0 -> only the terminator line is emitted, then batch_done=1.
